// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared constants and types for the pipeline stall sequencer.
//   - STOP / NO_STOP       : polarity of one stall-vector bit (1 = hold stage)
//   - STALL_* constants    : 6-bit stall vectors, bit0=PC ... bit5=WB
//   - mc_state_e           : mult/div sequencing FSM states
//   - reg_match()          : operand/destination compare used by hazard checks
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Each vector stops every stage below the bubble point; the first
    // NO_STOP bit above a STOP bit is where the bubble is injected.
    localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS_W-1:0] STALL_LUH  = 6'b000011;
    localparam logic [STALL_BUS_W-1:0] STALL_MC   = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MCS_IDLE  = 2'd0,
        MCS_START = 2'd1,
        MCS_WAIT  = 2'd2
    } mc_state_e;

    // True when an operand is actually read and names the destination.
    function automatic logic reg_match(input logic       use_reg,
                                       input logic [4:0] src_reg,
                                       input logic [4:0] dst_reg);
        return use_reg & (src_reg == dst_reg);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare between two source operands and the
// destination of a load one stage ahead. Register $0 never creates a hazard.
// Ports:
//   rs, rt          in  5  source registers of the consumer
//   use_rs, use_rt  in  1  consumer actually reads rs / rt
//   is_load         in  1  producer is a load
//   rf_we           in  1  producer writes the register file
//   rf_waddr        in  5  producer destination register
//   luh             out 1  load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic       is_load,
    input  logic       rf_we,
    input  logic [4:0] rf_waddr,
    output logic       luh
);

    logic producer_valid_s;

    // Combinational hazard compare; $0 is hard-wired zero so it is excluded.
    always_comb begin
        producer_valid_s = is_load & rf_we & (rf_waddr != 5'd0);
        luh = producer_valid_s
            & (reg_match(use_rs, rs, rf_waddr) | reg_match(use_rt, rt, rf_waddr));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/bubble sequencer for the 5-stage pipeline.
//   - load-use hazard detection (hazard_detect sub-module)
//   - mult/div start/ready sequencing FSM with a cycle watchdog
//   - data-SRAM wait absorption
//   - priority mux producing the per-stage stall vector
// Optional build macro: STALL_PERF_EN adds two wrapping performance counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs, id_rt             ID source registers
//   id_use_rs, id_use_rt     ID instruction reads rs / rt
//   ex_is_load, ex_rf_we     EX holds a load / writes regfile
//   ex_rf_waddr              EX destination register
//   ex_mc_req                EX needs the multi-cycle unit
//   mc_ready                 multi-cycle result valid
//   mem_wait                 data SRAM not ready
//   stall   [STALL_W]        [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   mc_start                 one-cycle start pulse (high only in MCS_START)
//   mc_timeout               sticky watchdog error, cleared only by rst
//   perf_stall_cycles        (STALL_PERF_EN) cycles with stall[0] set
//   perf_luh_bubbles         (STALL_PERF_EN) cycles the load-use term is chosen
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W       = 6,
    parameter int MC_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               ex_is_load,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic               ex_mc_req,
    input  logic               mc_ready,
    input  logic               mem_wait,
    output logic [STALL_W-1:0] stall,
    output logic               mc_start,
    output logic               mc_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_stall_cycles,
    output logic [CNT_W-1:0]   perf_luh_bubbles
`endif
);

    localparam int WC_W = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MC_MAX_CYCLES - 1);

    if ((STALL_W != STALL_BUS_W) || (MC_MAX_CYCLES < 2) || (CNT_W < 1)) begin : g_bad_param
        $error("pipe_stall_ctrl: illegal parameter combination");
    end

    mc_state_e       state_r;
    mc_state_e       state_next_s;
    logic [WC_W-1:0] wait_cnt_r;
    logic [WC_W-1:0] wait_cnt_next_s;
    logic            timeout_set_s;
    logic            luh_s;
    logic            mc_busy_s;
    logic            sel_luh_s;
    logic [5:0]      stall_s;

    hazard_detect u_hazard_detect (
        .rs       (id_rs),
        .rt       (id_rt),
        .use_rs   (id_use_rs),
        .use_rt   (id_use_rt),
        .is_load  (ex_is_load),
        .rf_we    (ex_rf_we),
        .rf_waddr (ex_rf_waddr),
        .luh      (luh_s)
    );

    // Next-state and watchdog counter logic for the mult/div sequencer.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        timeout_set_s   = 1'b0;
        case (state_r)
            MCS_IDLE: begin
                if (ex_mc_req) begin
                    state_next_s = MCS_START;
                end else begin
                    state_next_s = MCS_IDLE;
                end
            end
            MCS_START: begin
                state_next_s    = MCS_WAIT;
                wait_cnt_next_s = '0;
            end
            MCS_WAIT: begin
                // A ready result wins over a watchdog expiring in the same cycle.
                if (mc_ready) begin
                    state_next_s = MCS_IDLE;
                end else if (wait_cnt_r == WC_LAST) begin
                    state_next_s  = MCS_IDLE;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WC_W'(1);
                end
            end
            default: begin
                state_next_s    = MCS_IDLE;
                wait_cnt_next_s = '0;
            end
        endcase
    end

    // FSM state, watchdog count and registered handshake/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= MCS_IDLE;
            wait_cnt_r <= '0;
            mc_start   <= 1'b0;
            mc_timeout <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            // Registered from next state so the pulse coincides with MCS_START.
            mc_start   <= (state_next_s == MCS_START);
            mc_timeout <= mc_timeout | timeout_set_s;
        end
    end

    // Priority stall mux; the multi-cycle term drops out in the ready cycle
    // so EX advances together with the result.
    always_comb begin
        mc_busy_s = (state_r == MCS_START)
                  | ((state_r == MCS_WAIT) & ~mc_ready)
                  | ((state_r == MCS_IDLE) & ex_mc_req & ~mc_ready);
        sel_luh_s = 1'b0;
        if (rst) begin
            stall_s = STALL_NONE;
        end else if (mem_wait) begin
            stall_s = STALL_MEM;
        end else if (mc_busy_s) begin
            stall_s = STALL_MC;
        end else if (luh_s) begin
            stall_s   = STALL_LUH;
            sel_luh_s = 1'b1;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    assign stall = stall_s;

`ifdef STALL_PERF_EN
    // Wrapping performance counters for stalled cycles and load-use bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_luh_bubbles  <= '0;
        end else begin
            if (stall_s[0] == STOP) begin
                perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
            end else begin
                perf_stall_cycles <= perf_stall_cycles;
            end
            if (sel_luh_s) begin
                perf_luh_bubbles <= perf_luh_bubbles + CNT_W'(1);
            end else begin
                perf_luh_bubbles <= perf_luh_bubbles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int MC_MAX = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rf_waddr;
    logic       id_use_rs, id_use_rt, ex_is_load, ex_rf_we;
    logic       ex_mc_req, mc_ready, mem_wait;
    logic [5:0] stall;
    logic       mc_start, mc_timeout;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_luh_bubbles;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: which phase of a mult/div operation we are in,
    // how many cycles have been spent waiting for the result, error flag.
    int          m_phase;   // 0 = idle, 1 = start issued, 2 = waiting
    int          m_waited;
    logic        m_to;
    logic [31:0] m_pstall, m_pluh;

    pipe_stall_ctrl #(.STALL_W(6), .MC_MAX_CYCLES(MC_MAX), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_mc_req(ex_mc_req), .mc_ready(mc_ready), .mem_wait(mem_wait),
        .stall(stall), .mc_start(mc_start), .mc_timeout(mc_timeout)
`ifdef STALL_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_luh_bubbles(perf_luh_bubbles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic model_luh();
        if (!(ex_is_load && ex_rf_we) || ex_rf_waddr == 5'd0) return 1'b0;
        return (id_use_rs && id_rs == ex_rf_waddr) || (id_use_rt && id_rt == ex_rf_waddr);
    endfunction

    function automatic logic [5:0] model_stall();
        logic mc_hold;
        mc_hold = (m_phase == 1) || (m_phase == 2 && !mc_ready) ||
                  (m_phase == 0 && ex_mc_req && !mc_ready);
        if (rst)       return 6'b000000;
        if (mem_wait)  return 6'b011111;
        if (mc_hold)   return 6'b000111;
        if (model_luh()) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic set_idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0;
        ex_mc_req = 1'b0; mc_ready = 1'b0; mem_wait = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        logic [5:0] s;
        s = model_stall();
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_waited = 0; m_to = 1'b0; m_pstall = 0; m_pluh = 0;
        end else begin
            if (s[0]) m_pstall = m_pstall + 1;
            if (s == 6'b000011) m_pluh = m_pluh + 1;
            if (m_phase == 0) begin
                if (ex_mc_req) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2; m_waited = 0;
            end else begin
                m_waited = m_waited + 1;
                if (mc_ready) m_phase = 0;
                else if (m_waited == MC_MAX) begin m_phase = 0; m_to = 1'b1; end
            end
        end
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    endtask

    task automatic test_reset();
        set_idle_inputs(); mem_wait = 1'b1; ex_mc_req = 1'b1; rst = 1'b1;
        tick(); #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall_masked got=%b exp=%b", stall, 6'b000000); end
        set_idle_inputs(); tick(); rst = 1'b0; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b000000); end
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL reset_mc_start got=%b exp=0", mc_start); end
        checks++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL reset_mc_timeout got=%b exp=0", mc_timeout); end
`ifdef STALL_PERF_EN
        checks++; if (perf_stall_cycles !== 32'd0 || perf_luh_bubbles !== 32'd0) begin errors++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_stall_cycles, perf_luh_bubbles); end
`endif
    endtask

    task automatic test_luh();
        // lw $5 in EX, addu $6,$5,$7 in ID
        set_idle_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd5;
        id_rs = 5'd5; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b1; #1;
        checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL luh_hit got=%b exp=%b", stall, 6'b000011); end
        tick();
        // bubble now in EX, consumer still in ID
        ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL luh_release got=%b exp=%b", stall, 6'b000000); end
        // rt match only
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd7; #1;
        checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL luh_rt got=%b exp=%b", stall, 6'b000011); end
        // lw $0 with ID reading $0
        ex_rf_waddr = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL luh_r0 got=%b exp=%b", stall, 6'b000000); end
        // matching register but operands not used
        ex_rf_waddr = 5'd9; id_rs = 5'd9; id_rt = 5'd9; id_use_rs = 1'b0; id_use_rt = 1'b0; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL luh_unused got=%b exp=%b", stall, 6'b000000); end
        tick();
        set_idle_inputs(); #1;
    endtask

    task automatic test_div();
        int stalled;
        int pulses;
        do_reset();
        set_idle_inputs();
        stalled = 0; pulses = 0;
        ex_mc_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            if (stall == 6'b000111) stalled++;
            if (mc_start) pulses++;
            checks++; if (mc_start !== (i == 1)) begin errors++; $display("FAIL div_start_cycle%0d got=%b exp=%b", i, mc_start, (i == 1)); end
            tick();
        end
        mc_ready = 1'b1; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL div_ready_stall got=%b exp=%b", stall, 6'b000000); end
        checks++; if (stalled != 11 || pulses != 1) begin errors++; $display("FAIL div_counts got=%0d/%0d exp=11/1", stalled, pulses); end
        tick();
        // back-to-back request: must start a fresh operation
        mc_ready = 1'b0; #1;
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL div_b2b_stall got=%b exp=%b", stall, 6'b000111); end
        tick(); #1;
        checks++; if (mc_start !== 1'b1) begin errors++; $display("FAIL div_b2b_start got=%b exp=1", mc_start); end
        ex_mc_req = 1'b0;
        tick(); mc_ready = 1'b1; tick(); mc_ready = 1'b0; #1;
        checks++; if (stall !== 6'b000000 || mc_start !== 1'b0) begin errors++; $display("FAIL div_idle got=%b/%b exp=000000/0", stall, mc_start); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_idle_inputs();
        ex_mc_req = 1'b1; tick(); tick();
        mem_wait = 1'b1;
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL memw_hold%0d got=%b exp=%b", i, stall, 6'b011111); end
            tick();
        end
        mc_ready = 1'b1; #1;
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL memw_ready got=%b exp=%b", stall, 6'b011111); end
        tick();
        mc_ready = 1'b0; mem_wait = 1'b0; ex_mc_req = 1'b0; #1;
        checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL memw_luh_after got=%b exp=%b", stall, 6'b000011); end
        tick(); set_idle_inputs(); #1;
    endtask

    task automatic test_watchdog();
        do_reset();
        set_idle_inputs();
        ex_mc_req = 1'b1; tick(); ex_mc_req = 1'b0; tick();
        for (int i = 0; i < MC_MAX; i++) begin
            #1;
            checks++; if (mc_timeout !== 1'b0 || stall !== 6'b000111) begin errors++;
                $display("FAIL wd_wait%0d got=%b/%b exp=0/000111", i, mc_timeout, stall); end
            tick();
        end
        #1;
        checks++; if (mc_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout got=%b exp=1", mc_timeout); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL wd_idle got=%b exp=%b", stall, 6'b000000); end
        tick(); #1;
        checks++; if (mc_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", mc_timeout); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", mc_timeout); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_idle_inputs();
        ex_mc_req = 1'b1; tick(); tick(); tick(); tick();
        rst = 1'b1; #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL rstmid_comb got=%b exp=%b", stall, 6'b000000); end
        tick(); rst = 1'b0; ex_mc_req = 1'b0; #1;
        checks++; if (stall !== 6'b000000 || mc_start !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b/%b exp=000000/0", stall, mc_start); end
`ifdef STALL_PERF_EN
        checks++; if (perf_stall_cycles !== 32'd0 || perf_luh_bubbles !== 32'd0) begin errors++;
            $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_stall_cycles, perf_luh_bubbles); end
`endif
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse%0d got=%b exp=0", i, mc_start); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            ex_mc_req   = ($urandom_range(0, 99) < 25);
            mc_ready    = ($urandom_range(0, 99) < 20);
            mem_wait    = ($urandom_range(0, 99) < 15);
            ex_is_load  = $urandom_range(0, 1);
            ex_rf_we    = ($urandom_range(0, 3) != 0);
            ex_rf_waddr = 5'($urandom_range(0, 3));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = $urandom_range(0, 1);
            id_use_rt   = $urandom_range(0, 1);
            #1;
            checks++; if (stall !== model_stall()) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, model_stall()); end
            checks++; if (mc_start !== (m_phase == 1)) begin errors++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", i, mc_start, (m_phase == 1)); end
            checks++; if (mc_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, mc_timeout, m_to); end
`ifdef STALL_PERF_EN
            checks++; if (perf_stall_cycles !== m_pstall || perf_luh_bubbles !== m_pluh) begin errors++;
                $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, perf_stall_cycles, perf_luh_bubbles, m_pstall, m_pluh); end
`endif
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        m_phase = 0; m_waited = 0; m_to = 1'b0; m_pstall = 0; m_pluh = 0;
        set_idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_luh();
        test_div();
        test_mem_wait();
        test_watchdog();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
